// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller:
// state encodings and the default operand width.
package seq_mult_ctrl_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_adder_nbit.sv
// N-bit ripple-carry adder built as a chain of 1-bit full adders; the single
// shared adder that the multiplier controller steps across its iterations.
module adder_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         cout,
    output logic [N-1:0] s
);

    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing controller for an unsigned NxN shift-and-add multiplier that
// reuses one N-bit adder over N add/shift iterations and registers a 2N-bit product.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] P,
    output state_t         dbg_state
);

    localparam int CW = $clog2(N);

    // Handshake: Start is a request sampled only in IDLE (no ready signal; a
    // Start seen in any other state is dropped, never queued). Busy marks the
    // ADD/SHIFT iterations; Done is a one-cycle pulse when P holds the new product.

    state_t        state, state_next;
    logic [N-1:0]  mcand;
    logic [N-1:0]  hi;
    logic [N-1:0]  mq;
    logic          c;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sum;
    logic          cout;
    logic          last_iter;

    adder_nbit #(.N(N)) u_adder (
        .a    (hi),
        .b    (mcand),
        .cin  (1'b0),
        .cout (cout),
        .s    (sum)
    );

    assign last_iter = (cnt == CW'(N - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE:  state_next = Start ? ADD : IDLE;
            ADD: begin
                state_next = SHIFT;
                Busy       = 1'b1;
            end
            SHIFT: begin
                state_next = last_iter ? DONE : ADD;
                Busy       = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                Done       = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand <= '0;
            hi    <= '0;
            mq    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand <= A;
                        mq    <= B;
                        hi    <= '0;
                        c     <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    if (mq[0]) begin
                        hi <= sum;
                        c  <= cout;
                    end else begin
                        c  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // The adder carry lands in hi[N-1], so no product bit is lost.
                    hi <= {c, hi[N-1:1]};
                    mq <= {hi[0], mq[N-1:1]};
                    c  <= 1'b0;
                    if (last_iter) begin
                        P <= {c, hi, mq[N-1:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: directed scenarios plus a scoreboard
// that pairs every accepted Start with the product expected at its Done pulse.
module tb_seq_mult_ctrl;
    import seq_mult_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int PW = 2 * N;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          Busy;
    logic          Done;
    logic [PW-1:0] P;
    state_t        dbg_state;

    int checks;
    int errors;
    int done_count;

    logic [PW-1:0] exp_q[$];

    seq_mult_ctrl #(.N(N)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .P         (P),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // scoreboard: every Done pulse must match the oldest expected product
    always @(negedge Clock) begin
        if (!Reset && Done === 1'b1) begin
            logic [PW-1:0] exp;
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: Done=1 with P=%0d, no product was expected", P);
            end else begin
                exp = exp_q.pop_front();
                if (P !== exp) begin
                    errors++;
                    $display("FAIL product: P=%0d, expected %0d", P, exp);
                end
            end
        end
    end

    // driver tasks
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [PW-1:0] prod;
        @(negedge Clock);
        A     = a;
        B     = b;
        Start = 1'b1;
        prod  = PW'(a) * PW'(b);
        exp_q.push_back(prod);
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (Done !== 1'b1 && lat < 40) begin
            @(negedge Clock);
            lat++;
        end
        if (Done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: Done=%b after %0d cycles, expected 1", Done, lat);
        end
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge Clock);
        checks++;
        if (P !== '0 || Done !== 1'b0 || Busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: P=%0d Done=%b Busy=%b state=%0d, expected 0/0/0/0",
                     P, Done, Busy, dbg_state);
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (dbg_state !== IDLE || Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: state=%0d Busy=%b, expected 0/0", dbg_state, Busy);
        end
    endtask

    task automatic test_basic();
        int busy_bad;
        start_op(4'd5, 4'd3);
        busy_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) busy_bad++;
            @(negedge Clock);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_window: %0d of 8 cycles lacked Busy=1/Done=0, expected 0", busy_bad);
        end
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL done_latency: Done=%b Busy=%b on 8th edge, expected 1/0", Done, Busy);
        end
        @(negedge Clock);
        repeat (3) @(negedge Clock);
        checks++;
        if (Done !== 1'b0 || P !== 8'h0F) begin
            errors++;
            $display("FAIL p_hold: Done=%b P=%0d, expected 0/15", Done, P);
        end
    endtask

    task automatic test_patterns();
        logic [N-1:0] av[3];
        logic [N-1:0] bv[3];
        int lat;
        av = '{4'd15, 4'd9, 4'd0};
        bv = '{4'd15, 4'd7, 4'd13};
        for (int k = 0; k < 3; k++) begin
            start_op(av[k], bv[k]);
            wait_done(lat);
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL pattern_latency: %0dx%0d latency %0d, expected 8", av[k], bv[k], lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulse_cyc[3];
        int pulses;
        int cyc;
        int unstable;
        @(negedge Clock);
        A     = 4'd6;
        B     = 4'd7;
        Start = 1'b1;
        repeat (3) exp_q.push_back(8'd42);
        pulses   = 0;
        cyc      = 0;
        unstable = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge Clock);
            cyc++;
            if (Done === 1'b1) begin
                pulse_cyc[pulses] = cyc;
                pulses++;
            end else if (pulses > 0 && P !== 8'd42) begin
                unstable++;
            end
        end
        Start = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b_pulses: saw %0d Done pulses, expected 3", pulses);
        end else begin
            checks++;
            if (pulse_cyc[1] - pulse_cyc[0] != 10 || pulse_cyc[2] - pulse_cyc[1] != 10) begin
                errors++;
                $display("FAIL b2b_period: periods %0d,%0d, expected 10,10",
                         pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1]);
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL b2b_p_stable: P changed in %0d cycles, expected 0", unstable);
        end
        repeat (4) @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_idle: Busy=%b pending=%0d, expected 0/0", Busy, exp_q.size());
        end
    endtask

    task automatic test_ignore_start();
        int base;
        int lat;
        base = done_count;
        start_op(4'd3, 4'd4);
        repeat (2) @(negedge Clock);
        A     = 4'd15;
        B     = 4'd15;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_done(lat);
        repeat (15) @(negedge Clock);
        checks++;
        if (done_count - base != 1 || Busy !== 1'b0 || P !== 8'd12) begin
            errors++;
            $display("FAIL ignore_start: dones=%0d Busy=%b P=%0d, expected 1/0/12",
                     done_count - base, Busy, P);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        int base;
        @(negedge Clock);
        A     = 4'd11;
        B     = 4'd13;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if (dbg_state !== SHIFT) begin
            errors++;
            $display("FAIL reach_shift: state=%0d, expected %0d", dbg_state, SHIFT);
        end
        base = done_count;
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (P !== '0 || Done !== 1'b0 || Busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: P=%0d Done=%b Busy=%b state=%0d, expected 0/0/0/0",
                     P, Done, Busy, dbg_state);
        end
        @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        checks++;
        if (done_count != base || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d state=%0d, expected 0/0",
                     done_count - base, dbg_state);
        end
        start_op(4'd11, 4'd13);
        wait_done(lat);
        checks++;
        if (P !== 8'h8F) begin
            errors++;
            $display("FAIL after_reset: P=%0d, expected 143", P);
        end
    endtask

    task automatic test_sweep();
        int lat;
        int base;
        base = done_count;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(N'(a), N'(b));
                wait_done(lat);
            end
        end
        checks++;
        if (done_count - base != 256) begin
            errors++;
            $display("FAIL sweep_dones: %0d Done pulses, expected 256", done_count - base);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            start_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
            wait_done(lat);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done_count = 0;
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
        test_sweep();
        test_random();
        repeat (3) @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected products never produced, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
